// File: rtl/key_cmd_scheduler.sv
// Frame-synchronous key command scheduler: buffers one-hot key events and issues one per frame tick.
// Optional build macro KEY_SCHED_DEDUP_EN drops repeats of the newest still-queued event.
module key_cmd_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_FRAMES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vs,
  input  logic                          evt_valid,
  input  logic [3:0]                    evt_code,
  output logic                          evt_ready,
  output logic [3:0]                    key,
  output logic                          key_strobe,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD_FRAMES - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          r_state;
  logic            r_vs_q;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_key;
  logic            r_key_strobe;
  logic            r_overflow;
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic [AW:0]     r_level;
  logic [3:0]      r_mem [FIFO_DEPTH];

  logic            w_tick;
  logic            w_full;
  logic            w_onehot;
  logic            w_dup;
  logic            w_pop;
  logic            w_push;
  logic            w_drop_full;
  logic [3:0]      w_head;

  assign w_tick   = vs & ~r_vs_q;
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_onehot = (evt_code != 4'd0) && ((evt_code & (evt_code - 4'd1)) == 4'd0);
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  // A pop only happens when the FSM is ready to load a new command on this tick
  assign w_pop = w_tick && (r_level != '0) && ((r_state == S_IDLE) || (r_cnt == '0));

`ifdef KEY_SCHED_DEDUP_EN
  logic [3:0] r_last;

  // The newest entry counts as queued unless it is the sole entry leaving this cycle
  assign w_dup = (r_level != '0) && !(w_pop && (r_level == (AW+1)'(1))) && (evt_code == r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 4'd0;
    end else if (w_push) begin
      r_last <= evt_code;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // A pop on the same edge frees a slot, so a full FIFO still accepts the push
  assign w_push      = evt_valid && w_onehot && !w_dup && (!w_full || w_pop);
  assign w_drop_full = evt_valid && w_onehot && !w_dup && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= evt_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_q     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_vs_q <= vs;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - (AW+1)'(1);
      end
      if (w_drop_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_key        <= 4'd0;
      r_key_strobe <= 1'b0;
    end else begin
      r_key_strobe <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_IDLE: begin
            if (w_pop) begin
              r_key        <= w_head;
              r_key_strobe <= 1'b1;
              r_cnt        <= CNT_RELOAD;
              r_state      <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CW'(1);
            end else if (w_pop) begin
              r_key        <= w_head;
              r_key_strobe <= 1'b1;
              r_cnt        <= CNT_RELOAD;
            end else begin
              r_key   <= 4'd0;
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign evt_ready  = ~w_full;
  assign key        = r_key;
  assign key_strobe = r_key_strobe;
  assign overflow   = r_overflow;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler: one instance with HOLD_FRAMES=1, one with HOLD_FRAMES=2.
module tb_key_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0;
  logic       evt_valid = 1'b0;
  logic [3:0] evt_code = 4'd0;

  logic       rdy1, stb1, ovf1;
  logic [3:0] key1;
  logic [2:0] lvl1;
  logic       rdy2, stb2, ovf2;
  logic [3:0] key2;
  logic [2:0] lvl2;

  logic [3:0] cap_key1, cap_key2;
  logic       cap_stb1, cap_stb2;
  logic [2:0] cap_lvl1;

  int n_pass  = 0;
  int n_total = 0;
  int strobes = 0;

  logic [3:0] t3_exp [7] = '{4'd1, 4'd1, 4'd4, 4'd4, 4'd8, 4'd8, 4'd0};
  logic [3:0] t4_exp [4] = '{4'd2, 4'd4, 4'd8, 4'd0};

  always #5 clk = ~clk;

  key_cmd_scheduler #(.FIFO_DEPTH(4), .HOLD_FRAMES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ready(rdy1), .key(key1), .key_strobe(stb1), .overflow(ovf1), .fifo_level(lvl1)
  );

  key_cmd_scheduler #(.FIFO_DEPTH(4), .HOLD_FRAMES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_ready(rdy2), .key(key2), .key_strobe(stb2), .overflow(ovf2), .fifo_level(lvl2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] c);
    evt_valid = 1'b1;
    evt_code  = c;
    step();
    evt_valid = 1'b0;
    evt_code  = 4'd0;
  endtask

  // Raise vs, capture outputs right after the tick edge, then drop vs for one cycle
  task automatic frame();
    vs = 1'b1;
    step();
    cap_key1 = key1;
    cap_stb1 = stb1;
    cap_lvl1 = lvl1;
    cap_key2 = key2;
    cap_stb2 = stb2;
    vs = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    do_reset();
    check("rst_key", key1, 4'd0);
    check("rst_strobe", stb1, 1'b0);
    check("rst_overflow", ovf1, 1'b0);
    check("rst_level", lvl1, 3'd0);
    check("rst_ready", rdy1, 1'b1);

    // T1: asynchronous reset in the middle of a hold
    push(4'b0010);
    push(4'b0001);
    push(4'b1000);
    frame();
    check("t1_pre_key", key2, 4'b0010);
    check("t1_pre_level", lvl2, 3'd2);
    rst_n = 1'b0;
    #2;
    check("t1_async_key", key2, 4'd0);
    check("t1_async_level", lvl2, 3'd0);
    check("t1_async_overflow", ovf2, 1'b0);
    check("t1_async_ready", rdy2, 1'b1);
    step();
    rst_n = 1'b1;
    step();

    // T2: single event, HOLD_FRAMES=1
    push(4'b0001);
    check("t2_level", lvl1, 3'd1);
    frame();
    check("t2_tick_key", cap_key1, 4'b0001);
    check("t2_tick_strobe", cap_stb1, 1'b1);
    check("t2_tick_level", cap_lvl1, 3'd0);
    check("t2_after_strobe", stb1, 1'b0);
    check("t2_after_key", key1, 4'b0001);
    frame();
    check("t2_release_key", cap_key1, 4'd0);
    check("t2_release_strobe", cap_stb1, 1'b0);

    // T3: back-to-back commands, HOLD_FRAMES=2
    do_reset();
    push(4'b0001);
    push(4'b0100);
    push(4'b1000);
    check("t3_level", lvl2, 3'd3);
    strobes = 0;
    for (int i = 0; i < 7; i++) begin
      frame();
      check($sformatf("t3_key_tick%0d", i), cap_key2, t3_exp[i]);
      if (cap_stb2) strobes++;
    end
    check("t3_strobes", strobes, 3);
    check("t3_level_end", lvl2, 3'd0);

    // T4: overflow with no ticks
    do_reset();
    push(4'b0001);
    push(4'b0010);
    push(4'b0100);
    push(4'b1000);
    check("t4_full_level", lvl1, 3'd4);
    check("t4_full_ready", rdy1, 1'b0);
    check("t4_no_ovf_yet", ovf1, 1'b0);
    push(4'b0001);
    check("t4_overflow", ovf1, 1'b1);
    check("t4_level_after_drop", lvl1, 3'd4);
    frame();
    check("t4_pop_key", cap_key1, 4'b0001);
    check("t4_pop_level", lvl1, 3'd3);
    check("t4_pop_ready", rdy1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      frame();
      check($sformatf("t4_drain%0d", i), cap_key1, t4_exp[i]);
    end
    check("t4_ovf_sticky", ovf1, 1'b1);

    // T5: invalid codes, then push on the pop cycle of a full FIFO
    do_reset();
    push(4'b0000);
    push(4'b0011);
    check("t5_invalid_level", lvl1, 3'd0);
    check("t5_invalid_ovf", ovf1, 1'b0);
    push(4'b0001);
    push(4'b0010);
    push(4'b0100);
    push(4'b1000);
    check("t5_full_level", lvl1, 3'd4);
    vs        = 1'b1;
    evt_valid = 1'b1;
    evt_code  = 4'b0001;
    step();
    check("t5_sim_level", lvl1, 3'd4);
    check("t5_sim_ovf", ovf1, 1'b0);
    check("t5_sim_key", key1, 4'b0001);
    check("t5_sim_strobe", stb1, 1'b1);
    vs        = 1'b0;
    evt_valid = 1'b0;
    evt_code  = 4'd0;
    step();
    check("t5_post_level", lvl1, 3'd4);
    check("t5_post_ready", rdy1, 1'b0);

    // T6: identical consecutive events
    do_reset();
    push(4'b0010);
    push(4'b0010);
`ifdef KEY_SCHED_DEDUP_EN
    check("t6_dedup_level", lvl1, 3'd1);
`else
    check("t6_dup_level", lvl1, 3'd2);
`endif
    check("t6_ovf", ovf1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
